// File: rtl/pool2d_kxk_stream.sv
// rtl/pool2d_kxk_stream.sv - streaming KxK non-overlapping max/average pooling stage
module pool2d_kxk_stream #(
  parameter int DATA_COL_NUM = 28,
  parameter int DATA_ROW_NUM = 28,
  parameter int WORDLENGTH   = 16,
  parameter int POOL_K       = 2,
  parameter int ACC_W        = WORDLENGTH + 2 * $clog2(POOL_K)
) (
  input  logic                  clk,
  input  logic                  irst_n,
  input  logic                  sclr,
  input  logic                  in_valid,
  input  logic [WORDLENGTH-1:0] pixel_in,
  input  logic                  mode,
  output logic [WORDLENGTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  frame_done
);

  // Geometry derived from the parameters
  localparam int LOG_K   = $clog2(POOL_K);
  localparam int SHIFT   = 2 * LOG_K;
  localparam int SLOTS   = DATA_COL_NUM / POOL_K;
  localparam int COL_W   = (DATA_COL_NUM > 1) ? $clog2(DATA_COL_NUM) : 1;
  localparam int ROW_W   = (DATA_ROW_NUM > 1) ? $clog2(DATA_ROW_NUM) : 1;
  localparam int SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int COL_LIM = SLOTS * POOL_K;
  localparam int ROW_LIM = (DATA_ROW_NUM / POOL_K) * POOL_K;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DATA_COL_NUM - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DATA_ROW_NUM - 1);

  // Mode encoding on the mode input and in the latched copy
  localparam logic MODE_AVG = 1'b1;

  // Window geometry must be a power of two that fits inside the map
  if ((POOL_K < 2) || ((POOL_K & (POOL_K - 1)) != 0) ||
      (POOL_K > DATA_COL_NUM) || (POOL_K > DATA_ROW_NUM)) begin : g_bad_pool_k
    $error("pool2d_kxk_stream: POOL_K must be a power of two, >= 2 and <= map size");
  end

  logic [COL_W-1:0]        col_cnt;
  logic [ROW_W-1:0]        row_cnt;
  logic                    mode_q;

  logic signed [ACC_W-1:0] part_buf [SLOTS];

  logic                    accept;
  logic                    frame_start;
  logic                    eff_mode;
  logic                    col_end;
  logic                    row_end;
  logic                    in_region;
  logic                    win_first;
  logic                    win_last;
  logic [SLOT_W-1:0]       slot_idx;
  logic signed [ACC_W-1:0] slot_val;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] combined;
  logic [WORDLENGTH-1:0]   result;

  // sclr wins over in_valid, so a pixel presented alongside it is dropped
  assign accept      = in_valid & ~sclr;
  assign frame_start = (col_cnt == '0) && (row_cnt == '0);

  // The first pixel of a frame already combines with the live mode input
  assign eff_mode    = frame_start ? mode : mode_q;

  assign col_end     = (col_cnt == COL_LAST);
  assign row_end     = (row_cnt == ROW_LAST);

  // Remainder rows/columns (floor mode) are counted but never pooled
  assign in_region   = (32'(col_cnt) < COL_LIM) && (32'(row_cnt) < ROW_LIM);

  // Position inside the window comes from the low bits since POOL_K is a power of two
  assign win_first   = (col_cnt[LOG_K-1:0] == '0) && (row_cnt[LOG_K-1:0] == '0);
  assign win_last    = (&col_cnt[LOG_K-1:0]) && (&row_cnt[LOG_K-1:0]);

  assign slot_idx    = SLOT_W'(col_cnt >> LOG_K);
  assign slot_val    = part_buf[slot_idx];
  assign pix_ext     = ACC_W'($signed(pixel_in));

  // Merge the incoming pixel into its window partial; the window-first pixel just loads
  always_comb begin
    combined = pix_ext;
    if (!win_first) begin
      if (eff_mode == MODE_AVG) begin
        combined = slot_val + pix_ext;
      end else begin
        combined = (pix_ext > slot_val) ? pix_ext : slot_val;
      end
    end
  end

  // Average divides by K*K with an arithmetic shift (floor toward -inf); result always fits
  always_comb begin
    result = WORDLENGTH'(combined);
    if (eff_mode == MODE_AVG) begin
      result = WORDLENGTH'(combined >>> SHIFT);
    end
  end

  // Raster position counters, advancing only on accepted pixels and wrapping per frame
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (sclr) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Mode is captured with pixel (0,0) and held for the rest of the frame
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      mode_q <= 1'b0;
    end else if (sclr) begin
      mode_q <= 1'b0;
    end else if (accept && frame_start) begin
      mode_q <= mode;
    end
  end

  // Partial buffer needs no reset: every window's first pixel overwrites its slot
  always_ff @(posedge clk) begin
    if (accept && in_region) begin
      part_buf[slot_idx] <= combined;
    end
  end

  // Result register: pulse out_valid one cycle after a window closes, hold data otherwise
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (sclr) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= accept && in_region && win_last;
      frame_done <= accept && col_end && row_end;
      if (accept && in_region && win_last) begin
        data_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_pool2d_kxk_stream.sv
// tb/tb_pool2d_kxk_stream.sv - table-driven scoreboard bench for pool2d_kxk_stream
module tb_pool2d_kxk_stream;

  localparam int WL = 16;

  typedef struct packed {
    logic [WL-1:0] data;
    logic          done;
  } exp_t;

  typedef struct packed {
    logic                 mode;
    logic [15:0][WL-1:0]  pix;
    logic [3:0][WL-1:0]   expv;
  } vec_t;

  logic clk = 1'b0;
  logic irst_n;

  logic          sclr_a, valid_a, mode_a;
  logic [WL-1:0] pix_a, dout_a;
  logic          ov_a, fd_a;

  logic          sclr_b, valid_b, mode_b;
  logic [WL-1:0] pix_b, dout_b;
  logic          ov_b, fd_b;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool2d_kxk_stream #(
    .DATA_COL_NUM(4), .DATA_ROW_NUM(4), .WORDLENGTH(WL), .POOL_K(2)
  ) dut_a (
    .clk(clk), .irst_n(irst_n), .sclr(sclr_a), .in_valid(valid_a),
    .pixel_in(pix_a), .mode(mode_a), .data_out(dout_a),
    .out_valid(ov_a), .frame_done(fd_a)
  );

  pool2d_kxk_stream #(
    .DATA_COL_NUM(5), .DATA_ROW_NUM(5), .WORDLENGTH(WL), .POOL_K(2)
  ) dut_b (
    .clk(clk), .irst_n(irst_n), .sclr(sclr_b), .in_valid(valid_b),
    .pixel_in(pix_b), .mode(mode_b), .data_out(dout_b),
    .out_valid(ov_b), .frame_done(fd_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard for the 4x4 instance
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (irst_n) begin
      if (ov_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_spurious_out: got data %0d, expected no output", $signed(dout_a));
        end else begin
          e = q_a.pop_front();
          if (dout_a !== e.data || fd_a !== e.done) begin
            errors++;
            $display("FAIL a_out: got data %0d done %0d, expected data %0d done %0d",
                     $signed(dout_a), fd_a, $signed(e.data), e.done);
          end
        end
      end else if (fd_a) begin
        checks++;
        errors++;
        $display("FAIL a_spurious_done: got frame_done 1 without out_valid, expected 0");
      end
    end
  end

  // Scoreboard for the 5x5 instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (irst_n && ov_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_spurious_out: got data %0d, expected no output", $signed(dout_b));
      end else begin
        e = q_b.pop_front();
        if (dout_b !== e.data) begin
          errors++;
          $display("FAIL b_out: got data %0d, expected %0d", $signed(dout_b), $signed(e.data));
        end
      end
    end
  end

  task automatic set_win(input int i, input int w, input int a, input int b, input int c, input int d);
    int base;
    base = (w / 2) * 8 + (w % 2) * 2;
    vecs[i].pix[base]     = WL'(a);
    vecs[i].pix[base + 1] = WL'(b);
    vecs[i].pix[base + 4] = WL'(c);
    vecs[i].pix[base + 5] = WL'(d);
  endtask

  task automatic set_exp(input int i, input int e0, input int e1, input int e2, input int e3);
    vecs[i].expv[0] = WL'(e0);
    vecs[i].expv[1] = WL'(e1);
    vecs[i].expv[2] = WL'(e2);
    vecs[i].expv[3] = WL'(e3);
  endtask

  task automatic drive_a(input logic [WL-1:0] p, input logic m);
    @(negedge clk);
    sclr_a  = 1'b0;
    valid_a = 1'b1;
    pix_a   = p;
    mode_a  = m;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_a = 1'b0;
    end
  endtask

  // Drive one 4x4 frame from the table; optionally with random gaps and a mid-frame mode flip
  task automatic run_frame_a(input int i, input bit gaps, input bit toggle, input int npix);
    logic m;
    int   r, c;
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      if (gaps && k > 0) idle_a($urandom_range(0, 5));
      m = (toggle && k >= 8) ? ~vecs[i].mode : vecs[i].mode;
      drive_a(vecs[i].pix[k], m);
      r = k / 4;
      c = k % 4;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.data = vecs[i].expv[(r / 2) * 2 + c / 2];
        e.done = (k == 15);
        q_a.push_back(e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t eb;
    int   exp_b[4];
    int   nb;

    irst_n  = 1'b0;
    sclr_a  = 1'b0; valid_a = 1'b0; mode_a = 1'b0; pix_a = '0;
    sclr_b  = 1'b0; valid_b = 1'b0; mode_b = 1'b0; pix_b = '0;

    // Stimulus table: rising ramp (max / avg), negative avg, negative max
    vecs[0].mode = 1'b0;
    vecs[1].mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vecs[0].pix[k] = WL'(k);
      vecs[1].pix[k] = WL'(k);
    end
    set_exp(0, 5, 7, 13, 15);
    set_exp(1, 2, 4, 10, 12);
    vecs[2].mode = 1'b1;
    set_win(2, 0, -1, -2, -3, -4);
    set_win(2, 1, -1, -1, -1, -2);
    set_win(2, 2, 32767, 32767, 32767, 32767);
    set_win(2, 3, -32768, -32768, -32768, -32768);
    set_exp(2, -3, -2, 32767, -32768);
    vecs[3].mode = 1'b0;
    set_win(3, 0, -5, -7, -32768, -1);
    set_win(3, 1, -32768, -32768, -32768, -32768);
    set_win(3, 2, 3, -3, 0, 2);
    set_win(3, 3, 32767, -32768, 0, 0);
    set_exp(3, -1, -32768, 3, 32767);

    repeat (3) @(negedge clk);
    check("reset_a_data", int'(dout_a), 0);
    check("reset_a_valid", int'(ov_a), 0);
    check("reset_a_done", int'(fd_a), 0);
    check("reset_b_data", int'(dout_b), 0);
    check("reset_b_valid", int'(ov_b), 0);
    check("reset_b_done", int'(fd_b), 0);
    irst_n = 1'b1;

    // Table frames back-to-back with no idle cycle between them
    for (int i = 0; i < 4; i++) run_frame_a(i, 1'b0, 1'b0, 16);
    idle_a(3);
    check("table_queue_empty", q_a.size(), 0);

    // Random gaps plus mid-frame mode toggles, second frame back-to-back
    run_frame_a(0, 1'b1, 1'b1, 16);
    run_frame_a(1, 1'b1, 1'b1, 16);
    idle_a(3);
    check("gap_queue_empty", q_a.size(), 0);

    // Async reset mid-frame after 6 pixels (pixel 5 closes window 0)
    run_frame_a(0, 1'b0, 1'b0, 6);
    idle_a(1);
    #2 irst_n = 1'b0;
    #1;
    check("async_rst_data", int'(dout_a), 0);
    check("async_rst_valid", int'(ov_a), 0);
    check("async_rst_done", int'(fd_a), 0);
    @(negedge clk);
    irst_n = 1'b1;
    run_frame_a(0, 1'b0, 1'b0, 16);
    idle_a(3);
    check("post_rst_queue_empty", q_a.size(), 0);

    // sclr mid-frame together with in_valid: pixel dropped, counters restart
    run_frame_a(3, 1'b0, 1'b0, 3);
    @(negedge clk);
    sclr_a  = 1'b1;
    valid_a = 1'b1;
    pix_a   = WL'(7777);
    mode_a  = 1'b0;
    @(negedge clk);
    sclr_a  = 1'b0;
    valid_a = 1'b0;
    check("sclr_data", int'(dout_a), 0);
    check("sclr_valid", int'(ov_a), 0);
    check("sclr_done", int'(fd_a), 0);
    run_frame_a(1, 1'b0, 1'b0, 16);
    idle_a(3);
    check("post_sclr_queue_empty", q_a.size(), 0);

    // 5x5 remainder frame, max mode, ramp 0..24
    exp_b = '{6, 8, 16, 18};
    nb = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      valid_b = 1'b1;
      pix_b   = WL'(k);
      mode_b  = 1'b0;
      if ((k / 5 < 4) && (k % 5 < 4) && ((k / 5) % 2 == 1) && ((k % 5) % 2 == 1)) begin
        eb.data = WL'(exp_b[nb]);
        eb.done = 1'b0;
        q_b.push_back(eb);
        nb++;
      end
    end
    @(negedge clk);
    valid_b = 1'b0;
    check("b_frame_done", int'(fd_b), 1);
    check("b_no_out_on_last", int'(ov_b), 0);
    @(negedge clk);
    check("b_done_one_cycle", int'(fd_b), 0);
    repeat (2) @(negedge clk);
    check("b_queue_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
